// File: rtl/phase_detector_5bit.sv
// phase_detector_5bit: counter-based phase/frequency detector for the ADPLL.
// Measures the clk-cycle distance between synchronized rising edges of the
// reference and feedback clocks. The result is a sign-magnitude error with a
// one-cycle valid pulse.
// Optional lock detector: define PD_LOCK_DET_EN to add the lock output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first rising edge of a comparison
// REF_LEAD | ref edge seen first, counting cycles until fb edge
// FB_LEAD  | fb edge seen first, counting cycles until ref edge

module phase_detector_5bit #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int LOCK_THRESH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ref_in,
  input  logic       fb_in,
  output logic [4:0] error,
  output logic       error_sign,
  output logic       error_valid
`ifdef PD_LOCK_DET_EN
  ,
  output logic       lock
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REF_LEAD = 2'd1;
  localparam logic [1:0] ST_FB_LEAD  = 2'd2;
  localparam logic [4:0] CNT_MAX     = 5'd31;

  if (SYNC_STAGES < 2 || LOCK_COUNT < 1 || LOCK_COUNT > 15 ||
      LOCK_THRESH < 0 || LOCK_THRESH > 31) begin : g_bad_param
    $error("phase_detector_5bit: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] ref_sync_q;
  logic [SYNC_STAGES-1:0] fb_sync_q;
  logic                   ref_hist_q;
  logic                   fb_hist_q;
  logic                   rise_ref;
  logic                   rise_fb;

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       pub;
  logic [4:0] pub_err;
  logic       pub_sign;

  logic [4:0] error_q;
  logic       sign_q;
  logic       valid_q;

  // Input synchronizers followed by one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      ref_hist_q <= 1'b0;
      fb_hist_q  <= 1'b0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
      fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fb_in};
      ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
      fb_hist_q  <= fb_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_ref = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
  assign rise_fb  = fb_sync_q[SYNC_STAGES-1] & ~fb_hist_q;

  // Next-state, counter and publish decision
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pub      = 1'b0;
    pub_err  = 5'd0;
    pub_sign = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_ref && rise_fb) begin
          pub = 1'b1;
        end else if (rise_ref) begin
          cnt_d   = 5'd1;
          state_d = ST_REF_LEAD;
        end else if (rise_fb) begin
          cnt_d   = 5'd1;
          state_d = ST_FB_LEAD;
        end
      end
      ST_REF_LEAD: begin
        // lagging edge wins over a simultaneous repeat of the leading edge,
        // and the leading edge is then dropped rather than restarting
        if (rise_fb) begin
          pub     = 1'b1;
          pub_err = cnt_q;
          state_d = ST_IDLE;
        end else if (rise_ref) begin
          pub     = 1'b1;
          pub_err = CNT_MAX;
          cnt_d   = 5'd1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FB_LEAD: begin
        pub_sign = 1'b1;
        if (rise_ref) begin
          pub     = 1'b1;
          pub_err = cnt_q;
          state_d = ST_IDLE;
        end else if (rise_fb) begin
          pub     = 1'b1;
          pub_err = CNT_MAX;
          cnt_d   = 5'd1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // FSM state, counter and registered publish outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      error_q <= 5'd0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= pub ? pub_err : 5'd0;
      sign_q  <= pub & pub_sign;
      valid_q <= pub;
    end
  end

  assign error       = error_q;
  assign error_sign  = sign_q;
  assign error_valid = valid_q;

`ifdef PD_LOCK_DET_EN
  localparam logic [3:0] LOCK_COUNT_W  = 4'(LOCK_COUNT);
  localparam logic [4:0] LOCK_THRESH_W = 5'(LOCK_THRESH);

  logic [3:0] lock_cnt_q;

  // Count consecutive small-error measurements, clearing on any large one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= 4'd0;
    end else if (valid_q) begin
      if (error_q <= LOCK_THRESH_W) begin
        if (lock_cnt_q != LOCK_COUNT_W) lock_cnt_q <= lock_cnt_q + 4'd1;
      end else begin
        lock_cnt_q <= 4'd0;
      end
    end
  end

  assign lock = (lock_cnt_q == LOCK_COUNT_W);
`endif

endmodule

// File: tb/tb_phase_detector_5bit.sv
// Directed bench for phase_detector_5bit; lock checks only with PD_LOCK_DET_EN.
module tb_phase_detector_5bit;

  logic       clk;
  logic       reset;
  logic       ref_in;
  logic       fb_in;
  logic [4:0] error;
  logic       error_sign;
  logic       error_valid;
`ifdef PD_LOCK_DET_EN
  logic       lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  phase_detector_5bit dut (
    .clk         (clk),
    .reset       (reset),
    .ref_in      (ref_in),
    .fb_in       (fb_in),
    .error       (error),
    .error_sign  (error_sign),
    .error_valid (error_valid)
`ifdef PD_LOCK_DET_EN
    ,
    .lock        (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: log every valid pulse and count non-zero outputs outside pulses
  logic [5:0] pulses[$];
  int         stamps[$];
  logic       lock_at[$];
  logic       lock_nx[$];
  int         cyc      = 0;
  int         bad_idle = 0;
  logic       pend     = 1'b0;

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    pend <= error_valid;
`ifdef PD_LOCK_DET_EN
    if (pend) lock_nx.push_back(lock);
`endif
    if (error_valid) begin
      pulses.push_back({error_sign, error});
      stamps.push_back(cyc);
`ifdef PD_LOCK_DET_EN
      lock_at.push_back(lock);
`endif
    end else if (error != 5'd0 || error_sign != 1'b0) begin
      bad_idle <= bad_idle + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // n_per periods; each input high for 8 cycles from its offset (<0 = absent)
  task automatic gen(input int n_per, input int period, input int d_ref, input int d_fb);
    for (int p = 0; p < n_per; p++) begin
      for (int t = 0; t < period; t++) begin
        ref_in = (d_ref >= 0 && t >= d_ref && t < d_ref + 8);
        fb_in  = (d_fb >= 0 && t >= d_fb && t < d_fb + 8);
        tick();
      end
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (8) tick();
  endtask

  task automatic run_case(input string tag, input int n_per, input int period,
                          input int d_ref, input int d_fb, input int exp_n,
                          input int exp_err, input int exp_sign, output int base);
    int idle0;
    base  = pulses.size();
    idle0 = bad_idle;
    gen(n_per, period, d_ref, d_fb);
    chk({tag, "_count"}, pulses.size() - base, exp_n);
    for (int i = base; i < pulses.size(); i++)
      chk({tag, "_value"}, {26'd0, pulses[i]}, {26'd0, exp_sign[0], exp_err[4:0]});
    chk({tag, "_idle_zero"}, bad_idle - idle0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_error", error, 0);
    chk("rst_sign", error_sign, 0);
    chk("rst_valid", error_valid, 0);
`ifdef PD_LOCK_DET_EN
    chk("rst_lock", lock, 0);
`endif
    reset = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int b;
    int n0;
    reset  = 1'b1;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    do_reset();

    run_case("ref_lead5", 3, 64, 0, 5, 3, 5, 0, b);
    for (int i = b + 1; i < stamps.size(); i++)
      chk("ref_lead5_spacing", stamps[i] - stamps[i-1], 64);
    run_case("fb_lead3", 2, 64, 3, 0, 2, 3, 1, b);
    run_case("coincident", 2, 64, 0, 0, 2, 0, 0, b);
    run_case("dist1", 1, 64, 0, 1, 1, 1, 0, b);
    run_case("dist31", 1, 64, 0, 31, 1, 31, 0, b);
    run_case("fb_sat45", 1, 64, 45, 0, 1, 31, 1, b);
    run_case("ref_sat40", 1, 64, 0, 40, 1, 31, 0, b);
    run_case("ref_only20", 4, 20, 0, -1, 3, 31, 0, b);
    for (int i = b + 1; i < stamps.size(); i++)
      chk("ref_only20_spacing", stamps[i] - stamps[i-1], 20);

    // abort a measurement by reset 10 cycles into REF_LEAD
    do_reset();
    n0 = pulses.size();
    for (int t = 0; t < 14; t++) begin
      ref_in = (t < 8);
      tick();
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("mid_rst_valid", error_valid, 0);
    end
    reset = 1'b0;
    repeat (40) tick();
    chk("mid_rst_no_pulse", pulses.size() - n0, 0);
    run_case("after_rst2", 1, 64, 0, 2, 1, 2, 0, b);

`ifdef PD_LOCK_DET_EN
    run_case("lock_ramp", 8, 32, 0, 1, 8, 1, 0, b);
    chk("lock_before_8th", lock_at[b+7], 0);
    chk("lock_after_7th", lock_nx[b+6], 0);
    chk("lock_after_8th", lock_nx[b+7], 1);
    run_case("lock_drop", 1, 32, 0, 4, 1, 4, 0, b);
    chk("lock_at_err4", lock_at[b], 1);
    chk("lock_after_err4", lock_nx[b], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
